reg_mem_2r1w: RTL and testbench

//  Parametrised register-file memory: one write port, two independent registered read ports.

---
 rtl/reg_mem_2r1w.sv | 134 +++++++++++++
 tb/tb_reg_mem_2r1w.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mem_2r1w.sv
// Register-file memory with one write port and two registered read ports.
// A clear sequencer rewrites every entry with INIT_VAL after reset or on clr.

module reg_mem_rd_port #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  byp,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
         valid    <= 1'b0;
      end else begin
         valid <= en;
         if (en) data_out <= byp ? wr_data : mem_data;
      end
   end

endmodule

module reg_mem_2r1w #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    ADDR_BITS     = 5,
   parameter int                    WRITE_THROUGH = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL      = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   output logic                  busy,
   input  logic                  wen,
   input  logic [ADDR_BITS-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  ren_a,
   input  logic [ADDR_BITS-1:0]  raddr_a,
   output logic [DATA_WIDTH-1:0] data_out_a,
   output logic                  valid_a,
   input  logic                  ren_b,
   input  logic [ADDR_BITS-1:0]  raddr_b,
   output logic [DATA_WIDTH-1:0] data_out_b,
   output logic                  valid_b
);

   localparam int DEPTH     = 1 << ADDR_BITS;
   localparam int NUM_PORTS = 2;

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t                 state, state_nxt;
   logic [ADDR_BITS-1:0]   ptr, ptr_nxt;
   logic                   idle;
   logic                   wr_en;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic [NUM_PORTS-1:0]                 ren_v;
   logic [NUM_PORTS-1:0][ADDR_BITS-1:0]  raddr_v;
   logic [NUM_PORTS-1:0]                 byp_v;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_v;
   logic [NUM_PORTS-1:0]                 rvalid_v;

   assign idle  = (state == ST_IDLE);
   assign busy  = ~idle;
   // clr takes priority over a same-cycle write
   assign wr_en = idle & wen & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_INIT;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         ST_INIT: begin
            ptr_nxt = ptr + ADDR_BITS'(1);
            if (ptr == ADDR_BITS'(DEPTH - 1)) begin
               state_nxt = ST_IDLE;
               ptr_nxt   = '0;
            end
         end
         ST_IDLE: begin
            if (clr) begin
               state_nxt = ST_INIT;
               ptr_nxt   = '0;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   // Storage has no reset; the sequencer owns the write port while busy.
   always_ff @(posedge clk) begin
      if (!idle)      mem[ptr]   <= INIT_VAL;
      else if (wr_en) mem[waddr] <= data_in;
   end

   assign ren_v   = {ren_b, ren_a};
   assign raddr_v = {raddr_b, raddr_a};

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
      assign byp_v[p] = (WRITE_THROUGH != 0) && wr_en && (waddr == raddr_v[p]);

      reg_mem_rd_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (idle & ren_v[p]),
         .byp      (byp_v[p]),
         .mem_data (mem[raddr_v[p]]),
         .wr_data  (data_in),
         .data_out (rdata_v[p]),
         .valid    (rvalid_v[p])
      );
   end

   assign data_out_a = rdata_v[0];
   assign valid_a    = rvalid_v[0];
   assign data_out_b = rdata_v[1];
   assign valid_b    = rvalid_v[1];

endmodule

// File: tb/tb_reg_mem_2r1w.sv
// Bench for reg_mem_2r1w: a write-through and a read-old-data instance share stimulus
// and are compared against an array model of the memory.

module tb_reg_mem_2r1w;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0, wen = 1'b0, ren_a = 1'b0, ren_b = 1'b0;
   logic [4:0] waddr = '0, raddr_a = '0, raddr_b = '0;
   logic [7:0] data_in = '0;

   logic       busy_w, valid_a_w, valid_b_w, busy_n, valid_a_n, valid_b_n;
   logic [7:0] dout_a_w, dout_b_w, dout_a_n, dout_b_n;

   int   checks = 0;
   int   errors = 0;
   logic [7:0] model [32];

   always #5 clk = ~clk;

   reg_mem_2r1w #(.DATA_WIDTH(8), .ADDR_BITS(5), .WRITE_THROUGH(1), .INIT_VAL(8'h00)) dut_w (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_w),
      .wen(wen), .waddr(waddr), .data_in(data_in),
      .ren_a(ren_a), .raddr_a(raddr_a), .data_out_a(dout_a_w), .valid_a(valid_a_w),
      .ren_b(ren_b), .raddr_b(raddr_b), .data_out_b(dout_b_w), .valid_b(valid_b_w));

   reg_mem_2r1w #(.DATA_WIDTH(8), .ADDR_BITS(5), .WRITE_THROUGH(0), .INIT_VAL(8'h00)) dut_n (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_n),
      .wen(wen), .waddr(waddr), .data_in(data_in),
      .ren_a(ren_a), .raddr_a(raddr_a), .data_out_a(dout_a_n), .valid_a(valid_a_n),
      .ren_b(ren_b), .raddr_b(raddr_b), .data_out_b(dout_b_n), .valid_b(valid_b_n));

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic quiet();
      clr = 0; wen = 0; ren_a = 0; ren_b = 0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 8'h00;
   endtask

   // Counts edges until busy drops; a count other than 32 is a failure.
   task automatic expect_busy_32(input string name);
      int n = 0;
      while (busy_w && n < 100) begin tick(); n++; end
      checks++;
      if (n !== 32 || busy_n !== 1'b0) begin
         errors++; $display("FAIL %s busy_cycles got %0d want 32 (busy_n=%b)", name, n, busy_n);
      end
   endtask

   task automatic test_reset();
      rst_n = 0; quiet();
      tick(); tick();
      checks++;
      if ({busy_w, busy_n} !== 2'b11 || {valid_a_w, valid_b_w, valid_a_n, valid_b_n} !== 4'b0 ||
          {dout_a_w, dout_b_w, dout_a_n, dout_b_n} !== 32'h0) begin
         errors++; $display("FAIL reset_state busy=%b%b va=%b vb=%b a=%h b=%h want busy=11 rest 0",
                            busy_w, busy_n, valid_a_w, valid_b_w, dout_a_w, dout_b_w);
      end
      rst_n = 1;
      expect_busy_32("reset_release");
      clear_model();
      for (int i = 0; i < 32; i++) begin
         ren_a = 1; raddr_a = 5'(i); tick();
         checks++;
         if (!valid_a_w || dout_a_w !== model[i] || !valid_a_n || dout_a_n !== model[i]) begin
            errors++; $display("FAIL init_read addr %0d got %h/%h want %h", i, dout_a_w, dout_a_n, model[i]);
         end
      end
      quiet();
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 32; i++) begin
         wen = 1; waddr = 5'(i); data_in = 8'(i); model[i] = 8'(i); tick();
      end
      quiet();
      for (int i = 0; i < 32; i++) begin
         ren_a = 1; raddr_a = 5'(i); ren_b = 1; raddr_b = 5'(31 - i); tick();
         checks++;
         if (!valid_a_w || !valid_b_w || dout_a_w !== model[i] || dout_b_w !== model[31 - i] ||
             dout_a_n !== model[i] || dout_b_n !== model[31 - i]) begin
            errors++; $display("FAIL write_read i=%0d a=%h b=%h want a=%h b=%h", i, dout_a_w, dout_b_w,
                               model[i], model[31 - i]);
         end
      end
      quiet(); tick();
      checks++;
      if (valid_a_w || valid_b_w || dout_a_w !== model[31] || dout_b_w !== model[0]) begin
         errors++; $display("FAIL valid_one_cycle va=%b vb=%b a=%h b=%h want 0 0 %h %h",
                            valid_a_w, valid_b_w, dout_a_w, dout_b_w, model[31], model[0]);
      end
   endtask

   task automatic test_collision();
      wen = 1; waddr = 7; data_in = 8'h07; model[7] = 8'h07; tick();
      wen = 1; waddr = 7; data_in = 8'hA5; ren_a = 1; raddr_a = 7; ren_b = 1; raddr_b = 7; tick();
      checks++;
      if (dout_a_w !== 8'hA5 || dout_b_w !== 8'hA5 || dout_a_n !== 8'h07 || dout_b_n !== 8'h07) begin
         errors++; $display("FAIL collision wt a=%h b=%h want a5, nwt a=%h b=%h want 07",
                            dout_a_w, dout_b_w, dout_a_n, dout_b_n);
      end
      model[7] = 8'hA5;
      wen = 0; tick();
      checks++;
      if (dout_a_w !== 8'hA5 || dout_a_n !== 8'hA5 || dout_b_n !== 8'hA5) begin
         errors++; $display("FAIL collision_after got %h/%h want a5", dout_a_w, dout_a_n);
      end
      quiet();
   endtask

   task automatic test_clr();
      wen = 1; waddr = 3; data_in = 8'hFF; tick();
      wen = 1; waddr = 3; data_in = 8'h11; clr = 1; tick();
      quiet(); clear_model();
      expect_busy_32("clr");
      ren_a = 1; raddr_a = 3; tick();
      checks++;
      if (!valid_a_w || dout_a_w !== 8'h00 || dout_a_n !== 8'h00) begin
         errors++; $display("FAIL clr_read addr3 got %h/%h want 00", dout_a_w, dout_a_n);
      end
      quiet();
   endtask

   task automatic test_busy_ignore();
      clr = 1; tick(); clr = 0;
      for (int i = 0; i < 5; i++) tick();
      wen = 1; waddr = 0; data_in = 8'h55; ren_a = 1; raddr_a = 0; ren_b = 1; raddr_b = 3; tick();
      checks++;
      if (valid_a_w || valid_b_w || valid_a_n || dout_a_w !== 8'h00 || busy_w !== 1'b1) begin
         errors++; $display("FAIL busy_ignore va=%b vb=%b a=%h busy=%b want 0 0 00 1",
                            valid_a_w, valid_b_w, dout_a_w, busy_w);
      end
      quiet();
      begin
         int n = 0;
         while (busy_w && n < 100) begin tick(); n++; end
      end
      ren_a = 1; raddr_a = 0; tick();
      checks++;
      if (!valid_a_w || dout_a_w !== 8'h00 || dout_a_n !== 8'h00) begin
         errors++; $display("FAIL busy_write_dropped addr0 got %h/%h want 00", dout_a_w, dout_a_n);
      end
      quiet();
   endtask

   task automatic test_reset_mid_init();
      for (int i = 0; i < 32; i++) begin
         wen = 1; waddr = 5'(i); data_in = 8'($urandom_range(1, 255)); tick();
      end
      quiet();
      ren_a = 1; raddr_a = 31; tick(); quiet();
      clr = 1; tick(); clr = 0;
      for (int i = 0; i < 10; i++) tick();
      rst_n = 0; #1;
      checks++;
      if (!busy_w || valid_a_w || valid_b_w || dout_a_w !== 8'h00 || dout_b_w !== 8'h00 ||
          dout_a_n !== 8'h00) begin
         errors++; $display("FAIL mid_init_reset busy=%b va=%b a=%h b=%h want 1 0 00 00",
                            busy_w, valid_a_w, dout_a_w, dout_b_w);
      end
      tick(); tick();
      rst_n = 1;
      expect_busy_32("mid_init_release");
      clear_model();
      for (int i = 0; i < 32; i++) begin
         ren_a = 1; raddr_a = 5'(i); ren_b = 1; raddr_b = 5'(31 - i); tick();
         checks++;
         if (dout_a_w !== 8'h00 || dout_b_w !== 8'h00 || dout_a_n !== 8'h00 || dout_b_n !== 8'h00) begin
            errors++; $display("FAIL mid_init_read i=%0d a=%h b=%h want 00", i, dout_a_w, dout_b_w);
         end
      end
      quiet();
   endtask

   task automatic test_random();
      logic [7:0] ea_w, eb_w, ea_n, eb_n;
      logic       va, vb;
      for (int c = 0; c < 400; c++) begin
         wen     = 1'($urandom_range(0, 1));
         waddr   = 5'($urandom_range(0, 31));
         data_in = 8'($urandom);
         ren_a   = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         ren_b   = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 5'($urandom_range(0, 31));
         va = ren_a; vb = ren_b;
         if (ren_a) begin
            ea_n = model[raddr_a];
            ea_w = (wen && waddr == raddr_a) ? data_in : model[raddr_a];
         end
         if (ren_b) begin
            eb_n = model[raddr_b];
            eb_w = (wen && waddr == raddr_b) ? data_in : model[raddr_b];
         end
         if (wen) model[waddr] = data_in;
         tick();
         checks++;
         if (valid_a_w !== va || valid_b_w !== vb || valid_a_n !== va || valid_b_n !== vb ||
             dout_a_w !== ea_w || dout_b_w !== eb_w || dout_a_n !== ea_n || dout_b_n !== eb_n) begin
            errors++;
            $display("FAIL random c=%0d got v=%b%b a=%h b=%h na=%h nb=%h want v=%b%b a=%h b=%h na=%h nb=%h",
                     c, valid_a_w, valid_b_w, dout_a_w, dout_b_w, dout_a_n, dout_b_n,
                     va, vb, ea_w, eb_w, ea_n, eb_n);
         end
      end
      quiet();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_collision();
      test_clr();
      test_busy_ignore();
      test_reset_mid_init();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
